// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared opcode, operation and FSM state encodings for the EX ALU.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Main control aluOp field
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_OR   = 2'b11;

    // R-type func codes
    localparam int FN_ADD  = 0;
    localparam int FN_SUB  = 1;
    localparam int FN_AND  = 2;
    localparam int FN_OR   = 3;
    localparam int FN_SLT  = 4;
    localparam int FN_XOR  = 5;
    localparam int FN_NOR  = 6;
    localparam int FN_SLL  = 7;
    localparam int FN_MUL  = 8;
    localparam int FN_DIVU = 9;
    localparam int FN_REMU = 10;

    typedef enum logic [3:0] {
        CNT_ADD  = 4'd0,
        CNT_SUB  = 4'd1,
        CNT_AND  = 4'd2,
        CNT_OR   = 4'd3,
        CNT_SLT  = 4'd4,
        CNT_XOR  = 4'd5,
        CNT_NOR  = 4'd6,
        CNT_SLL  = 4'd7,
        CNT_MUL  = 4'd8,
        CNT_DIVU = 4'd9,
        CNT_REMU = 4'd10,
        CNT_ZERO = 4'd11
    } alu_cnt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } alu_state_e;

    function automatic logic is_div_op(alu_cnt_e c);
        return (c == CNT_DIVU) || (c == CNT_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_exec_if.sv
// ============================================================================
// Module  : alu_exec_if
// Purpose : Issue/result handshake bundle between the EX stage and the ALU.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_exec_if #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 4
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        aluOp;
    logic [FUNC_W-1:0] func;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              out_valid;
    logic [WIDTH-1:0]  result;
    logic              zero;
    logic              busy;

    modport slave (
        input  flush, in_valid, aluOp, func, a, b,
        output in_ready, out_valid, result, zero, busy
    );

    modport master (
        output flush, in_valid, aluOp, func, a, b,
        input  in_ready, out_valid, result, zero, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
// ============================================================================
// Module  : alu_iter_muldiv
// Purpose : One-bit-per-cycle shift-add multiplier / restoring divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             abort,
    input  wire logic             is_div,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic                  done,
    output logic [WIDTH-1:0]      hi_nxt,
    output logic [WIDTH-1:0]      lo_nxt
);
    localparam int CW = $clog2(WIDTH) + 1;

    // hi: product accumulator / partial remainder
    // lo: multiplier (shifting right) / dividend becoming quotient
    // op: multiplicand (shifting left) / divisor
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_op;

    logic [WIDTH-1:0] w_op_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;

    assign done = (r_cnt == CW'(1));

    always_comb begin
        w_rem_sh = {r_hi, r_lo[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, r_op};
        hi_nxt   = r_hi;
        lo_nxt   = r_lo;
        w_op_nxt = r_op;
        if (r_div) begin
            if (!w_diff[WIDTH]) begin
                hi_nxt = w_diff[WIDTH-1:0];
                lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = w_rem_sh[WIDTH-1:0];
                lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt   = r_lo[0] ? (r_hi + r_op) : r_hi;
            lo_nxt   = {1'b0, r_lo[WIDTH-1:1]};
            w_op_nxt = {r_op[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_op  <= '0;
        end else if (abort) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= CW'(WIDTH);
            r_div <= is_div;
            r_hi  <= '0;
            r_lo  <= is_div ? a : b;
            r_op  <= is_div ? b : a;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_hi  <= hi_nxt;
            r_lo  <= lo_nxt;
            r_op  <= w_op_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module  : alu_exec_unit
// Purpose : Execute-stage ALU with control decode, iterative mul/div, stall.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 4
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    alu_exec_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e        r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_out_valid;
    logic              r_want_rem;

    alu_cnt_e          w_cnt;
    logic [FUNC_W-1:0] w_func;
    logic [WIDTH-1:0]  w_single;
    logic              w_iter;
    logic              w_accept;
    logic              w_start;
    logic              w_load;
    logic [WIDTH-1:0]  w_load_val;
    logic              w_done;
    logic [WIDTH-1:0]  w_hi_nxt;
    logic [WIDTH-1:0]  w_lo_nxt;

    assign w_func = bus.func;

    always_comb begin
        w_cnt = CNT_ZERO;
        case (bus.aluOp)
            ALUOP_ADD: w_cnt = CNT_ADD;
            ALUOP_SUB: w_cnt = CNT_SUB;
            ALUOP_OR:  w_cnt = CNT_OR;
            default: begin
                case (w_func)
                    FUNC_W'(FN_ADD):  w_cnt = CNT_ADD;
                    FUNC_W'(FN_SUB):  w_cnt = CNT_SUB;
                    FUNC_W'(FN_AND):  w_cnt = CNT_AND;
                    FUNC_W'(FN_OR):   w_cnt = CNT_OR;
                    FUNC_W'(FN_SLT):  w_cnt = CNT_SLT;
                    FUNC_W'(FN_XOR):  w_cnt = CNT_XOR;
                    FUNC_W'(FN_NOR):  w_cnt = CNT_NOR;
                    FUNC_W'(FN_SLL):  w_cnt = CNT_SLL;
                    FUNC_W'(FN_MUL):  w_cnt = CNT_MUL;
                    FUNC_W'(FN_DIVU): w_cnt = CNT_DIVU;
                    FUNC_W'(FN_REMU): w_cnt = CNT_REMU;
                    default:          w_cnt = CNT_ZERO;
                endcase
            end
        endcase
    end

    // Divide by zero resolves here in one cycle instead of iterating
    always_comb begin
        w_single = '0;
        case (w_cnt)
            CNT_ADD:  w_single = bus.a + bus.b;
            CNT_SUB:  w_single = bus.a - bus.b;
            CNT_AND:  w_single = bus.a & bus.b;
            CNT_OR:   w_single = bus.a | bus.b;
            CNT_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            CNT_XOR:  w_single = bus.a ^ bus.b;
            CNT_NOR:  w_single = ~(bus.a | bus.b);
            CNT_SLL:  w_single = bus.a << bus.b[SHW-1:0];
            CNT_DIVU: w_single = '1;
            CNT_REMU: w_single = bus.a;
            default:  w_single = '0;
        endcase
    end

    assign w_iter   = (w_cnt == CNT_MUL) || (is_div_op(w_cnt) && (bus.b != '0));
    assign w_accept = bus.in_valid && (r_state == ST_IDLE) && !bus.flush;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_load_val  = w_single;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_iter) begin
                        w_start     = 1'b1;
                        w_state_nxt = (w_cnt == CNT_MUL) ? ST_MUL : ST_DIV;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                w_load_val = (r_state == ST_DIV && !r_want_rem) ? w_lo_nxt : w_hi_nxt;
                if (w_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
            w_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
            r_want_rem  <= 1'b0;
        end else begin
            r_out_valid <= w_load;
            if (w_load) begin
                r_result <= w_load_val;
                r_zero   <= (w_load_val == '0);
            end
            if (w_start) begin
                r_want_rem <= (w_cnt == CNT_REMU);
            end
        end
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .abort  (bus.flush),
        .is_div (is_div_op(w_cnt)),
        .a      (bus.a),
        .b      (bus.b),
        .done   (w_done),
        .hi_nxt (w_hi_nxt),
        .lo_nxt (w_lo_nxt)
    );

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module  : tb_alu_exec_unit
// Purpose : Directed self-checking bench for alu_exec_unit at WIDTH=8.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;
    localparam int WIDTH  = 8;
    localparam int FUNC_W = 4;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    alu_exec_if #(.WIDTH(WIDTH), .FUNC_W(FUNC_W)) bus ();

    alu_exec_unit #(
        .WIDTH  (WIDTH),
        .FUNC_W (FUNC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for exactly one edge; returns 1ns after that edge
    task automatic issue(input logic [1:0] op, input logic [3:0] fn,
                         input logic [7:0] x, input logic [7:0] y);
        bus.aluOp    = op;
        bus.func     = fn;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [7:0] exp);
        check_eq({tag, "_ov"},   32'(bus.out_valid), 32'd1);
        check_eq({tag, "_res"},  32'(bus.result),    32'(exp));
        check_eq({tag, "_zero"}, 32'(bus.zero),      32'(exp == 8'd0));
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rdy"},  32'(bus.in_ready),  32'd1);
        check_eq({tag, "_ov"},   32'(bus.out_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy),      32'd0);
        check_eq({tag, "_res"},  32'(bus.result),    32'd0);
        check_eq({tag, "_zero"}, 32'(bus.zero),      32'd1);
    endtask

    initial begin
        int n;
        int ov_cnt;
        n_assert     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.aluOp    = 2'b00;
        bus.func     = 4'd0;
        bus.a        = 8'd0;
        bus.b        = 8'd0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        check_eq("rdy_after_rst", 32'(bus.in_ready), 32'd1);

        // single-cycle ops, issued back to back
        issue(2'b00, 4'd0, 8'd5, 8'd3);       check_res("add", 8'd8);
        issue(2'b01, 4'd0, 8'd9, 8'd9);       check_res("sub", 8'd0);
        issue(2'b10, 4'd4, 8'hFF, 8'h01);     check_res("slt", 8'd1);
        issue(2'b10, 4'd7, 8'h03, 8'h0A);     check_res("sll", 8'h0C);
        issue(2'b10, 4'd2, 8'hF0, 8'h3C);     check_res("and", 8'h30);
        issue(2'b10, 4'd5, 8'hF0, 8'h3C);     check_res("xor", 8'hCC);
        issue(2'b10, 4'd6, 8'hF0, 8'h0E);     check_res("nor", 8'h01);
        issue(2'b11, 4'd0, 8'h50, 8'h05);     check_res("or",  8'h55);
        issue(2'b10, 4'd1, 8'h03, 8'h05);     check_res("subf", 8'hFE);
        issue(2'b10, 4'd12, 8'h05, 8'h07);    check_res("fn12", 8'h00);
        tick();
        check_eq("ov_pulse", 32'(bus.out_valid), 32'd0);

        // mul 7x6 with an op offered while busy
        issue(2'b10, 4'd8, 8'd7, 8'd6);
        for (int c = 1; c <= WIDTH; c++) begin
            check_eq("mul_busy", 32'(bus.busy),      32'd1);
            check_eq("mul_nrdy", 32'(bus.in_ready),  32'd0);
            check_eq("mul_noov", 32'(bus.out_valid), 32'd0);
            if (c == 3) begin
                bus.aluOp = 2'b00; bus.a = 8'd1; bus.b = 8'd1; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        check_res("mul", 8'd42);
        check_eq("mul_rdy",  32'(bus.in_ready), 32'd1);
        check_eq("mul_idle", 32'(bus.busy),     32'd0);
        tick();
        check_eq("mul_pulse", 32'(bus.out_valid), 32'd0);

        // iterative divide / remainder
        issue(2'b10, 4'd9, 8'd100, 8'd7);
        wait_ov(n);
        check_eq("divu_lat", 32'(n), 32'(WIDTH));
        check_res("divu", 8'd14);
        issue(2'b10, 4'd10, 8'd100, 8'd7);
        wait_ov(n);
        check_eq("remu_lat", 32'(n), 32'(WIDTH));
        check_res("remu", 8'd2);
        issue(2'b10, 4'd9, 8'd200, 8'd1);
        wait_ov(n);
        check_res("divu_by1", 8'd200);

        // divide by zero is single-cycle
        issue(2'b10, 4'd9, 8'd5, 8'd0);
        check_res("div0", 8'hFF);
        check_eq("div0_busy", 32'(bus.busy), 32'd0);
        issue(2'b10, 4'd10, 8'd5, 8'd0);
        check_res("rem0", 8'd5);

        // flush mid-multiply
        issue(2'b10, 4'd8, 8'd3, 8'd3);
        repeat (3) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_eq("flush_idle", 32'(bus.busy),      32'd0);
        check_eq("flush_rdy",  32'(bus.in_ready),  32'd1);
        check_eq("flush_noov", 32'(bus.out_valid), 32'd0);
        check_eq("flush_res",  32'(bus.result),    32'd5);
        ov_cnt = 0;
        repeat (12) begin
            tick();
            if (bus.out_valid) ov_cnt++;
        end
        check_eq("flush_quiet", 32'(ov_cnt),      32'd0);
        check_eq("flush_keep",  32'(bus.result),  32'd5);

        // flush together with in_valid drops the op
        bus.flush = 1'b1;
        issue(2'b00, 4'd0, 8'd2, 8'd2);
        bus.flush = 1'b0;
        check_eq("flushv_noov", 32'(bus.out_valid), 32'd0);
        check_eq("flushv_res",  32'(bus.result),    32'd5);
        tick();
        check_eq("flushv_idle", 32'(bus.busy), 32'd0);

        // asynchronous reset mid-operation
        issue(2'b10, 4'd8, 8'd9, 8'd9);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        tick();
        rst_n = 1'b1;
        ov_cnt = 0;
        repeat (12) begin
            tick();
            if (bus.out_valid) ov_cnt++;
        end
        check_eq("rst_quiet", 32'(ov_cnt),       32'd0);
        check_eq("rst_rdy",   32'(bus.in_ready), 32'd1);
        issue(2'b00, 4'd0, 8'd2, 8'd2);
        check_res("post_rst_add", 8'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
